// File: rtl/key_pkg.sv
// Shared types and 100 MHz default timing constants for the key conditioning blocks.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } key_state_t;

  localparam int unsigned STABLE_CYCLES_DEF = 1_000_000;
  localparam int unsigned HOLD_CYCLES_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Step-button conditioner: synchronise, debounce, then emit press/release/auto-repeat pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_repeat_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam int unsigned TMR_W = $clog2(maxU(HOLD_CYCLES, REPEAT_CYCLES));

  logic             keySync;
  logic             sampledPress;
  logic             accept;
  logic             holdDone;
  logic             repDone;

  logic [CNT_W-1:0] stableCnt_q, stableCnt_d;
  logic             level_q, level_d;
  key_state_t       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk100_i),
    .rst_ni (rstn_i),
    .d_i    (key_i),
    .q_o    (keySync)
  );

  // Button is active-low; work in "1 = pressed" from here on.
  assign sampledPress = ~keySync;

  always_comb begin
    stableCnt_d = '0;
    level_d     = level_q;
    accept      = 1'b0;
    if (sampledPress != level_q) begin
      if (stableCnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
        accept  = 1'b1;
        level_d = sampledPress;
      end else begin
        stableCnt_d = stableCnt_q + CNT_W'(1);
      end
    end
  end

  assign holdDone = (timer_q == TMR_W'(HOLD_CYCLES - 1));
  assign repDone  = (timer_q == TMR_W'(REPEAT_CYCLES - 1));

  // HELD and REPEAT share one timer; an accepted release always beats a timer expiry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && sampledPress) begin
          state_d = HELD;
          press_d = 1'b1;
          timer_d = '0;
        end
      end
      HELD: begin
        if (accept) begin
          state_d   = IDLE;
          release_d = 1'b1;
          timer_d   = '0;
        end else if (holdDone) begin
          timer_d = '0;
          if (REPEAT_EN) begin
            state_d  = REPEAT;
            repeat_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      REPEAT: begin
        if (accept) begin
          state_d   = IDLE;
          release_d = 1'b1;
          timer_d   = '0;
        end else if (repDone) begin
          repeat_d = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stableCnt_q <= '0;
      level_q     <= 1'b0;
      state_q     <= IDLE;
      timer_q     <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      stableCnt_q <= stableCnt_d;
      level_q     <= level_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_repeat_o  = repeat_q;

endmodule
